// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks.
//   sc_state_e : window control states
//   lfsr_taps  : maximal-length Fibonacci tap mask for widths 8..16
//                (bit k set means stage k+1 feeds the XOR)
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sc_state_e;

    localparam int unsigned MaxLfsrW = 16;

    function automatic logic [MaxLfsrW-1:0] lfsr_taps(input int unsigned width);
        logic [MaxLfsrW-1:0] taps;
        case (width)
            8:       taps = 16'h00B8; // 8,6,5,4
            9:       taps = 16'h0110; // 9,5
            10:      taps = 16'h0240; // 10,7
            11:      taps = 16'h0500; // 11,9
            12:      taps = 16'h0829; // 12,6,4,1
            13:      taps = 16'h100D; // 13,4,3,1
            14:      taps = 16'h2015; // 14,5,3,1
            15:      taps = 16'h6000; // 15,14
            16:      taps = 16'hD008; // 16,15,13,4
            default: taps = 16'h00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/scaled_addsub_unit_if.sv
// Bus between a stream source/sink (master) and scaled_addsub_unit (slave).
//   start, seed, mode     : window control (master -> slave)
//   in_bits, in_valid     : input streams (master -> slave)
//   out_bit, out_valid    : output stream (slave -> master)
//   count, done           : window result (slave -> master)
interface scaled_addsub_unit_if #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned LFSR_W = 8,
    parameter int unsigned WIN_W  = 8
);
    logic              start;
    logic [LFSR_W-1:0] seed;
    logic [N_IN-1:0]   mode;
    logic [N_IN-1:0]   in_bits;
    logic              in_valid;
    logic              out_bit;
    logic              out_valid;
    logic [WIN_W:0]    count;
    logic              done;

    modport master (
        output start, seed, mode, in_bits, in_valid,
        input  out_bit, out_valid, count, done
    );

    modport slave (
        input  start, seed, mode, in_bits, in_valid,
        output out_bit, out_valid, count, done
    );
endinterface

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR, shift-left, feedback into bit 0.
//   clk, reset : clock, async active-high reset (state -> 1)
//   load       : load seed (a zero seed loads as 1); wins over enable
//   enable     : advance one step
//   seed       : load value
//   state      : current register contents
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [Width-1:0] seed,
    output logic [Width-1:0] state
);
    localparam logic [Width-1:0] Taps = Width'(lfsr_taps(Width));
    localparam logic [Width-1:0] One  = Width'(1);

    logic [Width-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            // All-zero is the lock-up state of an XOR LFSR.
            state_d = (seed == '0) ? One : seed;
        end else if (enable) begin
            state_d = {state_q[Width-2:0], ^(state_q & Taps)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= One;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/scaled_addsub_unit.sv
// Stochastic scaled adder/subtractor: each valid cycle one input stream is
// picked by an LFSR, optionally inverted, and registered onto out_bit. The
// ones on out_bit are counted over a window of 2^WIN_W valid samples.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of scaled_addsub_unit_if (control, streams, result)
module scaled_addsub_unit
    import sc_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned LFSR_W = 8,
    parameter int unsigned WIN_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    scaled_addsub_unit_if.slave bus
);
    localparam int unsigned SelW = $clog2(N_IN);

    sc_state_e         state_q, state_d;
    logic [N_IN-1:0]   mode_q, mode_d;
    logic [WIN_W:0]    acc_q, acc_d;
    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;
    logic [WIN_W:0]    count_q, count_d;
    logic              done_q, done_d;

    logic              lfsr_load, lfsr_en;
    logic [LFSR_W-1:0] lfsr_state;
    logic [SelW-1:0]   sel;
    logic              sample_bit;

    sc_lfsr #(
        .Width (LFSR_W)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (bus.seed),
        .state  (lfsr_state)
    );

    assign sel        = lfsr_state[SelW-1:0];
    assign sample_bit = bus.in_bits[sel] ^ mode_q[sel];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        count_d     = count_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;

        if (bus.start) begin
            // A coincident valid sample is dropped; count is left untouched.
            state_d   = StRun;
            mode_d    = bus.mode;
            acc_d     = '0;
            cnt_d     = '0;
            lfsr_load = 1'b1;
        end else if (state_q == StRun && bus.in_valid) begin
            out_bit_d   = sample_bit;
            out_valid_d = 1'b1;
            lfsr_en     = 1'b1;
            acc_d       = acc_q + (WIN_W + 1)'(sample_bit);
            cnt_d       = cnt_q + WIN_W'(1);
            if (cnt_q == '1) begin
                count_d = acc_q + (WIN_W + 1)'(sample_bit);
                done_d  = 1'b1;
                acc_d   = '0;
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
endmodule

// File: doc/scaled_addsub_unit.md
SCALED_ADDSUB_UNIT -- requirements
Module: scaled_addsub_unit

Interface
REQ-001 Parameter N_IN, default 2, number of stochastic input streams; power of two, 2..8.
REQ-002 Parameter LFSR_W, default 8, select-LFSR width; 8..16.
REQ-003 Parameter WIN_W, default 8, log2 of the accumulation window length in valid samples.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; loads seed, clears accumulator, begins a window.
REQ-007 seed  input  LFSR_W  select-LFSR seed, sampled on start.
REQ-008 mode  input  N_IN  per-input polarity; 1 = input inverted (subtracted), 0 = passed (added); sampled on start.
REQ-009 in_bits  input  N_IN  one bit per stream, qualified by in_valid.
REQ-010 in_valid  input  1  in_bits valid this cycle.
REQ-011 out_bit  output  1  scaled sum/difference stream bit.
REQ-012 out_valid  output  1  out_bit valid this cycle.
REQ-013 count  output  WIN_W+1  number of ones in out_bit over the completed window.
REQ-014 done  output  1  one-cycle pulse; window complete, count valid.

Function
REQ-015 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on final window sample; DONE->RUN on start; start in RUN restarts the window (reload seed and mode, clear accumulator and sample counter).
REQ-016 Select index sel = low log2(N_IN) bits of the LFSR; LFSR is maximal-length Fibonacci, taps per LFSR_W from the package table.
REQ-017 seed value 0 loads as 1 (no lock-up).
REQ-018 In RUN with in_valid=1: out_bit <= in_bits[sel] XOR mode_reg[sel], out_valid <= 1, LFSR advances one step; latency exactly 1 cycle.
REQ-019 in_valid=0, or state IDLE/DONE: out_valid <= 0, LFSR, sample counter and accumulator hold; out_bit holds last value.
REQ-020 Accumulator adds each registered out_bit; window = exactly 2^WIN_W valid samples; gaps in in_valid do not shorten it.
REQ-021 On the final sample edge: count <= accumulator + final bit, done <= 1 for one cycle, coincident with the final out_valid; state -> DONE.
REQ-022 count holds until the next done; not cleared by start.
REQ-023 start coincident with in_valid: the sample is dropped; the new window's first sample is the next valid cycle.
REQ-024 Full window of ones: count = 2^WIN_W (width WIN_W+1, no overflow).
REQ-025 N_IN=2, mode=2'b10: out = sel ? ~in_bits[1] : in_bits[0] (scaled subtraction a-b).

Reset
REQ-026 reset asserted: state IDLE, LFSR = 1, mode_reg = 0, accumulator and sample counter = 0, out_bit = 0, out_valid = 0, count = 0, done = 0, immediately and asynchronously.
REQ-027 reset mid-RUN aborts the window; no done pulse; start required after release.

Structure
REQ-028 Shared package sc_pkg holds the state enum and the LFSR tap table function indexed by width.
REQ-029 One sub-module sc_lfsr (width parameter, load, enable, seed, state out); reused by other stochastic blocks.

Verification
REQ-030 N_IN=2, WIN_W=8, mode=10, in_bits[0]=1, in_bits[1]=0 constant, 256 valid cycles -> every out_bit=1, count=256, done once on 256th out_valid.
REQ-031 Same config, in_bits[0]=0, in_bits[1]=1 -> count=0, done pulse.
REQ-032 N_IN=4, mode=0000, random in_bits, seed=8'hA5, in_valid 50% duty -> out_bit and count match bit-exact model; done after 256th valid sample only.
REQ-033 seed=0 -> output sequence identical to seed=1 run.
REQ-034 reset asserted at sample 100 -> all outputs 0 same cycle, no done; start after release -> fresh full window.
REQ-035 start at sample 50 of RUN -> accumulator cleared, done only after 256 further valid samples, count reflects new window only.
